// File: rtl/md_wr_arb_if.sv
// md_wr_arb_if: handshake bundle between the write requesters, the
// arbiter/FIFO and the memory write port.
//   req/ai_in : per-driver write request and address (driver i owns bit i
//               and slice [i*AW +: AW])
//   gnt       : one-hot grant, same cycle as acceptance
//   we_o/ai_o : memory write valid/address (FIFO head)
//   rdy_i     : memory accepts the write this cycle
//   full/cnt  : FIFO status
// master = requesters + memory side, slave = md_wr_arb.
interface md_wr_arb_if #(
  parameter int N     = 2,
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]    req;
  logic [N*AW-1:0] ai_in;
  logic [N-1:0]    gnt;
  logic            we_o;
  logic [AW-1:0]   ai_o;
  logic            rdy_i;
  logic            full;
  logic [CW-1:0]   cnt;

  modport master (output req, ai_in, rdy_i, input gnt, we_o, ai_o, full, cnt);
  modport slave  (input req, ai_in, rdy_i, output gnt, we_o, ai_o, full, cnt);
endinterface

// File: rtl/md_wr_arb.sv
// md_wr_arb: arbitrates N write requesters onto one memory write port.
// Granted addresses are queued in a DEPTH-entry FIFO and issued to memory
// with a we_o/rdy_i valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : md_wr_arb_if.slave (req, ai_in, gnt, we_o, ai_o, rdy_i,
//                full, cnt)
// Build option:
//   MD_WR_ARB_FIXPRI_EN defined -> fixed priority (lowest index wins, no
//   round-robin pointer); undefined -> round-robin arbitration.

// Per-driver slice: raises its grant bit and forwards its address when it
// is the selected winner; addresses from all lanes are OR-combined.
module md_wr_arb_lane #(
  parameter int IW  = 1,
  parameter int AW  = 8,
  parameter int IDX = 0
) (
  input  logic          accept,
  input  logic [IW-1:0] gidx,
  input  logic [AW-1:0] ai,
  output logic          gnt,
  output logic [AW-1:0] ai_sel
);
  localparam logic [IW-1:0] ME = IDX[IW-1:0];

  assign gnt    = accept && (gidx == ME);
  assign ai_sel = gnt ? ai : '0;
endmodule

module md_wr_arb #(
  parameter int N     = 2,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  md_wr_arb_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][AW-1:0] mem;
  logic [PW-1:0]            wptr, rptr;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            gidx;
  logic                     hit;
  int                       idx;
  logic                     pop, push, accept;
  logic [N-1:0][AW-1:0]     ai_sel;
  logic [AW-1:0]            pdata;

  assign pop    = bus.we_o && bus.rdy_i;
  // Gated by rst_n so no grant leaks out while the block is held in reset.
  assign accept = rst_n && (|bus.req) && (!bus.full || pop);
  assign push   = accept;

`ifdef MD_WR_ARB_FIXPRI_EN
  // Lowest requesting index wins; no pointer state.
  always_comb begin
    gidx = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 0; k < N; k++) begin
      idx = k;
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        gidx = IW'(idx);
      end
    end
  end
`else
  logic [IW-1:0] rr;

  // Search rr, rr+1, ... mod N; explicit wrap keeps non-power-of-2 N correct.
  always_comb begin
    gidx = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        gidx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr <= '0;
    else if (accept)
      rr <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    md_wr_arb_lane #(.IW(IW), .AW(AW), .IDX(i)) u_lane (
      .accept (accept),
      .gidx   (gidx),
      .ai     (bus.ai_in[i*AW +: AW]),
      .gnt    (bus.gnt[i]),
      .ai_sel (ai_sel[i])
    );
  end

  always_comb begin
    pdata = '0;
    for (int i = 0; i < N; i++) pdata = pdata | ai_sel[i];
  end

  // Pointers wrap naturally (DEPTH is a power of 2); cnt alone decides
  // full/empty. Storage is reset so ai_o reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= pdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.cnt  = cnt;
  assign bus.we_o = (cnt != '0);
  assign bus.full = (cnt == CW'(DEPTH));
  assign bus.ai_o = mem[rptr];
endmodule

// File: doc/md_wr_arb.md
Name: md_wr_arb

Overview:
- Downstream consumer of the multi-driver write-request stage. Each driver presents a write-enable/address request; this block arbitrates among the N requesters and queues the granted addresses in a small FIFO.
- It issues the queued addresses one at a time to a single memory write port, using a valid/ready handshake.
- It replaces direct wiring of several drivers onto one shared we/ai bus, so only one driver's address is issued per accepted write.

Parameters:
- N, 2, number of requesting drivers (2..8).
- AW, 8, address width of each request.
- DEPTH, 4, FIFO entries (power of 2, 2..16).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-driver write request (the driver's we); bit i belongs to driver i.
- ai_in  in  N*AW  per-driver address; slice [i*AW +: AW] belongs to driver i.
- gnt  out  N  one-hot grant, combinational, same cycle as acceptance.
- we_o  out  1  memory write valid (FIFO non-empty).
- ai_o  out  AW  memory write address (FIFO head).
- rdy_i  in  1  memory accepts the write this cycle.
- full  out  1  FIFO holds DEPTH entries.
- cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - rr pointer = 0, FIFO read/write pointers = 0, cnt = 0.
  - we_o = 0, full = 0, ai_o = 0, gnt = 0.
  - Reset mid-operation discards all queued entries immediately; there is no flush handshake.
- Handshake rules:
  - Requester side: a driver holds req and its address stable until it sees gnt[i]=1 in the same cycle. The transfer completes on that clock edge.
  - Memory side: a write transfers on any edge where we_o=1 and rdy_i=1. ai_o is stable while we_o=1 and rdy_i=0.
- Acceptance: accept = (|req) && (!full || pop), where pop = we_o && rdy_i.
  - A write into a full FIFO is allowed when a pop happens in the same cycle.
  - When accept=0, gnt = 0.
- Round-robin arbitration (default):
  - Grant the first index with req set, searching rr, rr+1, … mod N.
  - On accept, rr <= granted index + 1 mod N. Without accept, rr holds.
  - Exactly one gnt bit is set per accepted cycle; never more than one.
- FIFO:
  - Push writes the granted ai_in slice at wptr; wptr increments, wrapping at DEPTH.
  - Pop increments rptr, wrapping at DEPTH.
  - cnt: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - ai_o = mem[rptr]; we_o = (cnt != 0); full = (cnt == DEPTH).
- Latency: a request accepted into an empty FIFO appears on we_o/ai_o in the next cycle. No bypass path from req to we_o.
- Boundary conditions:
  - Empty FIFO with rdy_i=1: no pop, cnt stays 0.
  - Full FIFO, no pop: gnt = 0 and requesters stall.
  - Full FIFO, pop and req both active: push and pop in the same cycle, cnt stays DEPTH.
  - Pointers are ordinary wrapping counters; full versus empty is decided by cnt only.
- No state machine beyond the pointers. rr is a $clog2(N)-bit register; wrap logic is correct for N values that are not powers of 2.

Optional Feature:
- Macro: MD_WR_ARB_FIXPRI_EN.
- Defined: fixed priority arbitration. The lowest-index requester always wins, and the rr register is not implemented. Acceptance rules and FIFO behaviour are unchanged.
- Undefined: round-robin arbitration as described above.

Test Plan:
- Reset, then release with N=2 and idle inputs -> we_o=0, cnt=0, gnt=00. Assert rst_n=0 while cnt=3 -> cnt=0 and we_o=0 immediately, without waiting for a clock edge.
- Round-robin fairness: req=11 held 4 cycles with rdy_i=1, ai_in={8'h08,8'h00} -> gnt sequence 01,10,01,10; ai_o sequence 00,08,00,08, each one cycle after its grant.
- Fill and stall: DEPTH=4, rdy_i=0, req=01 with ai=00..05 -> first 4 accepted, full=1 on cycle 4, gnt=00 afterwards; driver stalls on address 04.
- Simultaneous push and pop at full: full=1, rdy_i=1, req=10 -> gnt=10, cnt stays 4, ai_o advances to the next entry; after 4 further pops without req -> cnt=0, we_o=0.
- Memory backpressure: rdy_i toggles 0/1 each cycle -> ai_o held while rdy_i=0; every queued address is issued exactly once, in order.
- MD_WR_ARB_FIXPRI_EN defined, req=11 held, rdy_i=1 -> gnt=01 every cycle and driver 1 is never granted.
